// File: rtl/word_gen_dispatch.sv
// Round-robin dispatcher: pops candidates from word_storage byte-serially and
// streams each one, with its IDs, to a single ready hash core.
module word_gen_dispatch #(
    parameter int unsigned N_CORES      = 4,
    parameter int unsigned WORD_MAX_LEN = 16,
    localparam int unsigned AW = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1,
    localparam int unsigned LW = $clog2(WORD_MAX_LEN + 1),
    localparam int unsigned IW = $clog2(N_CORES)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         din,
    output logic [AW-1:0]      rd_addr,
    output logic               set_empty,
    input  logic               empty,
    input  logic [LW-1:0]      word_len,
    input  logic [15:0]        pkt_id,
    input  logic [15:0]        word_id,
    input  logic [31:0]        gen_id,
    input  logic               gen_end,
    input  logic [N_CORES-1:0] core_ready,
    output logic [N_CORES-1:0] core_wr_en,
    output logic [7:0]         core_dout,
    output logic               core_first,
    output logic               core_last,
    output logic [LW-1:0]      core_len,
    output logic [15:0]        core_pkt_id,
    output logic [15:0]        core_word_id,
    output logic [31:0]        core_gen_id,
    output logic               gen_end_out,
    output logic [31:0]        words_sent
);

    typedef enum logic [2:0] {IDLE, ARB, READ, GAP, END} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, grant, grant_c;
    logic          found;
    logic [LW-1:0] cnt, eff_len;
    logic          issue, drain;
    logic          valid_q, first_q, last_q;

    // A zero-length word still occupies one strobe carrying a 0 byte.
    assign eff_len = (core_len == '0) ? LW'(1) : core_len;
    assign issue   = (state == READ) && (cnt < eff_len);
    assign drain   = (state == READ) && !issue;

    always_comb begin
        state_n = state;
        found   = 1'b0;
        grant_c = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + i;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!found && core_ready[idx[IW-1:0]]) begin
                found   = 1'b1;
                grant_c = idx[IW-1:0];
            end
        end
        case (state)
            IDLE:    if (!empty) state_n = gen_end ? END : ARB;
            ARB:     if (found) state_n = READ;
            READ:    if (drain) state_n = GAP;
            GAP:     state_n = IDLE;
            END:     state_n = GAP;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        core_wr_en = '0;
        if (valid_q) core_wr_en[grant] = 1'b1;
    end

    assign core_dout   = (valid_q && core_len != '0) ? din : '0;
    assign core_first  = valid_q & first_q;
    assign core_last   = valid_q & last_q;
    assign set_empty   = drain || (state == END);
    assign gen_end_out = (state == END);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            cnt          <= '0;
            rd_addr      <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            core_len     <= '0;
            core_pkt_id  <= '0;
            core_word_id <= '0;
            core_gen_id  <= '0;
            words_sent   <= '0;
        end else begin
            state   <= state_n;
            valid_q <= issue;
            first_q <= issue && (cnt == '0);
            last_q  <= issue && (cnt == eff_len - LW'(1));
            case (state)
                ARB: begin
                    rd_addr <= '0;
                    cnt     <= '0;
                    if (found) begin
                        grant        <= grant_c;
                        core_len     <= word_len;
                        core_pkt_id  <= pkt_id;
                        core_word_id <= word_id;
                        core_gen_id  <= gen_id;
                    end
                end
                READ: begin
                    if (issue) begin
                        cnt <= cnt + LW'(1);
                        // rd_addr tracks cnt but holds at len-1
                        if ((cnt + LW'(1)) < core_len) rd_addr <= rd_addr + AW'(1);
                    end else begin
                        rr_ptr     <= (grant == IW'(N_CORES - 1)) ? '0 : grant + IW'(1);
                        words_sent <= words_sent + 32'd1;
                    end
                end
                GAP:     rd_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_gen_dispatch.sv
// Bench for word_gen_dispatch: word_storage model, cycle-schedule reference model,
// directed scenarios followed by randomized traffic.
module tb_word_gen_dispatch;

    localparam int NC   = 4;
    localparam int WL   = 16;
    localparam int MAXC = 20000;

    logic        CLK = 0, RESET = 0;
    logic [7:0]  din = '0;
    logic [3:0]  rd_addr;
    logic        set_empty, empty = 1'b1;
    logic [4:0]  word_len = '0;
    logic [15:0] pkt_id = '0, word_id = '0;
    logic [31:0] gen_id = '0;
    logic        gen_end = 1'b0;
    logic [3:0]  core_ready = '0;
    logic [3:0]  core_wr_en;
    logic [7:0]  core_dout;
    logic        core_first, core_last;
    logic [4:0]  core_len;
    logic [15:0] core_pkt_id, core_word_id;
    logic [31:0] core_gen_id;
    logic        gen_end_out;
    logic [31:0] words_sent;

    always #5 CLK = ~CLK;

    word_gen_dispatch #(.N_CORES(NC), .WORD_MAX_LEN(WL)) dut (
        .CLK(CLK), .RESET(RESET), .din(din), .rd_addr(rd_addr), .set_empty(set_empty),
        .empty(empty), .word_len(word_len), .pkt_id(pkt_id), .word_id(word_id),
        .gen_id(gen_id), .gen_end(gen_end), .core_ready(core_ready),
        .core_wr_en(core_wr_en), .core_dout(core_dout), .core_first(core_first),
        .core_last(core_last), .core_len(core_len), .core_pkt_id(core_pkt_id),
        .core_word_id(core_word_id), .core_gen_id(core_gen_id),
        .gen_end_out(gen_end_out), .words_sent(words_sent)
    );

    typedef struct {
        int           len;
        logic [15:0]  pkt;
        logic [15:0]  wid;
        logic [31:0]  gid;
        bit           ge;
        logic [127:0] data;
    } cand_t;

    cand_t pend[$];
    cand_t cur;
    bit    st_full = 0;

    int n_vec = 0, n_err = 0;
    int cyc = 0;

    // Expected outputs scheduled per cycle by the reference model
    bit [3:0]  e_wr[MAXC];
    bit [7:0]  e_dout[MAXC];
    bit        e_first[MAXC], e_last[MAXC], e_se[MAXC], e_ge[MAXC], ws_step[MAXC];
    int        e_len[MAXC];
    bit [15:0] e_pkt[MAXC], e_wid[MAXC];
    bit [31:0] e_gid[MAXC];

    int m_mode = 0, m_t = 0, m_rr = 0, m_ws = 0;
    bit prev_rst = 1;

    int g_log[$];
    int f_cyc[$];
    int b_log[$];
    int ge_cnt = 0;

    bit       rand_ready = 0, rand_load = 0;
    bit [3:0] ready_val = 4'hF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_word(input int len, input logic [15:0] pkt, input logic [15:0] wid,
                             input logic [31:0] gid, input bit ge, input logic [127:0] data);
        cand_t c;
        c.len = len; c.pkt = pkt; c.wid = wid; c.gid = gid; c.ge = ge; c.data = data;
        pend.push_back(c);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            if (pend.size() == 0 && !st_full && m_mode == 0 && cyc >= m_t) return;
        end
        n_vec++; n_err++;
        $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    endtask

    // Per-cycle: compare, model planning, then storage / ready update
    initial begin : cycle_proc
        bit         se_s;
        logic [3:0] ra_s;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                chk("rst_wr_en", core_wr_en, 0);
                chk("rst_set_empty", set_empty, 0);
                chk("rst_gen_end_out", gen_end_out, 0);
                chk("rst_words_sent", words_sent, 0);
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_first_last", {core_first, core_last}, 0);
                chk("rst_dout", core_dout, 0);
                for (int i = cyc; i < MAXC; i++) begin
                    e_wr[i] = 0; e_se[i] = 0; e_ge[i] = 0; ws_step[i] = 0;
                end
                prev_rst = 1;
            end else begin
                if (prev_rst) begin
                    m_mode = 0; m_t = cyc; m_rr = 0; m_ws = 0; prev_rst = 0;
                end
                m_ws += ws_step[cyc];
                chk("wr_en", core_wr_en, e_wr[cyc]);
                chk("set_empty", set_empty, e_se[cyc]);
                chk("gen_end_out", gen_end_out, e_ge[cyc]);
                chk("words_sent", words_sent, m_ws);
                if (e_wr[cyc] != 0) begin
                    chk("dout", core_dout, e_dout[cyc]);
                    chk("first", core_first, e_first[cyc]);
                    chk("last", core_last, e_last[cyc]);
                    chk("len", core_len, e_len[cyc]);
                    chk("pkt_id", core_pkt_id, e_pkt[cyc]);
                    chk("word_id", core_word_id, e_wid[cyc]);
                    chk("gen_id", core_gen_id, e_gid[cyc]);
                end
                if (core_wr_en != 0) begin
                    b_log.push_back(int'(core_dout));
                    if (core_first) begin
                        for (int k = 0; k < NC; k++) if (core_wr_en[k]) g_log.push_back(k);
                        f_cyc.push_back(cyc);
                    end
                end
                if (gen_end_out) ge_cnt++;
                if (cyc >= m_t) begin
                    if (m_mode == 0) begin
                        if (st_full) begin
                            if (cur.ge) begin
                                e_se[cyc+1] = 1; e_ge[cyc+1] = 1; m_t = cyc + 3;
                            end else begin
                                m_mode = 1; m_t = cyc + 1;
                            end
                        end
                    end else begin
                        int g, L;
                        chk("rd_addr_arb", rd_addr, 0);
                        g = -1;
                        for (int k = 0; k < NC; k++)
                            if (g < 0 && core_ready[(m_rr + k) % NC]) g = (m_rr + k) % NC;
                        if (g >= 0) begin
                            L = (cur.len == 0) ? 1 : cur.len;
                            if (cyc + L + 4 >= MAXC) begin
                                $display("FAIL cycle_budget: cycle %0d exceeds %0d", cyc, MAXC);
                                $fatal(1);
                            end
                            for (int k = 0; k < L; k++) begin
                                int s;
                                s = cyc + 2 + k;
                                e_wr[s]    = 4'(1 << g);
                                e_dout[s]  = (cur.len == 0) ? 8'h00 : cur.data[k*8 +: 8];
                                e_first[s] = (k == 0);
                                e_last[s]  = (k == L - 1);
                                e_se[s]    = (k == L - 1);
                                e_len[s]   = cur.len;
                                e_pkt[s]   = cur.pkt;
                                e_wid[s]   = cur.wid;
                                e_gid[s]   = cur.gid;
                            end
                            ws_step[cyc + 2 + L] = 1;
                            m_rr = (g + 1) % NC;
                            m_mode = 0;
                            m_t = cyc + 3 + L;
                        end else begin
                            m_t = cyc + 1;
                        end
                    end
                end
            end
            se_s = set_empty;
            ra_s = rd_addr;
            @(posedge CLK);
            #1;
            cyc++;
            if (se_s) st_full = 0;
            else if (!st_full && pend.size() > 0 && (!rand_load || $urandom_range(0, 2) != 0)) begin
                cur = pend.pop_front();
                st_full = 1;
            end
            begin
                int ai;
                ai = int'(ra_s);
                din = cur.data[ai*8 +: 8];
            end
            empty    = !st_full;
            word_len = 5'(cur.len);
            pkt_id   = cur.pkt;
            word_id  = cur.wid;
            gen_id   = cur.gid;
            gen_end  = cur.ge;
            core_ready = rand_ready ? 4'($urandom_range(0, 15)) : ready_val;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : seq
        int           n;
        bit           seen;
        logic [127:0] d8;
        cur.len = 0; cur.pkt = 0; cur.wid = 0; cur.gid = 0; cur.ge = 0; cur.data = '0;
        #1 RESET = 1;
        repeat (3) @(posedge CLK);
        #2 RESET = 0;

        // "abc" to core 0
        ready_val = 4'hF;
        push_word(3, 16'h0001, 16'd5, 32'd7, 0, 128'h636261);
        wait_drain(200);
        chk("t1_words_sent", words_sent, 1);
        chk("t1_grant", g_log[0], 0);
        chk("t1_byte_a", b_log[0], 8'h61);
        chk("t1_byte_b", b_log[1], 8'h62);
        chk("t1_byte_c", b_log[2], 8'h63);

        // back-to-back words: rotation and len+4 spacing
        push_word(2, 16'h0002, 16'd10, 32'd100, 0, 128'hA1A0);
        push_word(5, 16'h0002, 16'd11, 32'd101, 0, 128'hB4B3B2B1B0);
        push_word(1, 16'h0002, 16'd12, 32'd102, 0, 128'hC0);
        wait_drain(200);
        chk("t2_grant1", g_log[1], 1);
        chk("t2_grant2", g_log[2], 2);
        chk("t2_grant3", g_log[3], 3);
        chk("t2_spacing_a", f_cyc[2] - f_cyc[1], 6);
        chk("t2_spacing_b", f_cyc[3] - f_cyc[2], 9);

        // restricted ready sets with wrap of the pointer
        ready_val = 4'b0100;
        push_word(4, 16'h0003, 16'd20, 32'd200, 0, 128'hD3D2D1D0);
        wait_drain(200);
        ready_val = 4'b0011;
        push_word(2, 16'h0003, 16'd21, 32'd201, 0, 128'hE1E0);
        wait_drain(200);
        chk("t3_grant_c2", g_log[4], 2);
        chk("t3_grant_c0", g_log[5], 0);

        // zero-length word then end-of-list dummy
        ready_val = 4'hF;
        push_word(0, 16'h0004, 16'd30, 32'd300, 0, 128'hFF);
        push_word(0, 16'h0004, 16'd31, 32'd301, 1, 128'h0);
        wait_drain(200);
        chk("t4_grant", g_log[6], 1);
        chk("t4_len0_byte", b_log[b_log.size()-1], 0);
        chk("t4_words_sent", words_sent, 7);
        chk("t4_gen_end_pulses", ge_cnt, 1);

        // no core ready for a while
        ready_val = 4'b0000;
        push_word(3, 16'h0005, 16'd40, 32'd400, 0, 128'h171615);
        repeat (22) @(posedge CLK);
        chk("t5_words_held", words_sent, 7);
        chk("t5_rd_addr_held", rd_addr, 0);
        ready_val = 4'b1000;
        wait_drain(200);
        chk("t5_grant", g_log[7], 3);
        chk("t5_words_sent", words_sent, 8);

        // randomized traffic
        rand_ready = 1; rand_load = 1;
        for (int i = 0; i < 60; i++)
            push_word($urandom_range(0, WL), 16'($urandom), 16'($urandom), $urandom,
                      ($urandom_range(0, 9) == 0), {$urandom, $urandom, $urandom, $urandom});
        wait_drain(6000);

        // reset on the second strobe of an 8-byte word
        rand_ready = 0; rand_load = 0; ready_val = 4'hF;
        n = g_log.size();
        d8 = 128'h0807060504030201;
        push_word(8, 16'h0006, 16'd50, 32'd500, 0, d8);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (core_wr_en != 0 && core_first) seen = 1;
        end
        chk("t6_first_strobe_seen", seen, 1);
        @(posedge CLK);
        #2 RESET = 1;
        #1;
        chk("t6_rst_wr_en", core_wr_en, 0);
        chk("t6_rst_set_empty", set_empty, 0);
        chk("t6_rst_words_sent", words_sent, 0);
        repeat (2) @(posedge CLK);
        #2 RESET = 0;
        wait_drain(200);
        chk("t6_dispatch_count", g_log.size(), n + 2);
        chk("t6_regrant_core0", g_log[g_log.size()-1], 0);
        chk("t6_words_sent", words_sent, 1);
        for (int k = 0; k < 8; k++)
            chk("t6_resent_byte", b_log[b_log.size() - 8 + k], d8[k*8 +: 8]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
